// File: rtl/awgn_pkg.sv
// Shared widths and tag format for resources time-shared between AWGN channels.
package awgn_pkg;

    localparam int LOG_DIN_W  = 48;
    localparam int LOG_DOUT_W = 31;
    localparam int MAX_NREQ   = 8;
    localparam int TAG_ID_W   = $clog2(MAX_NREQ);

    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/log_req_arbiter_rr.sv
// Combinational round-robin pick: first set bit of i_req at or above i_ptr, with wrap.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [IW-1:0] i_ptr,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    int   w_pos;
    logic w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = IW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/log_req_arbiter.sv
// Shares one fixed-latency log unit between NREQ requesters; a tag pipeline
// steers each result back to the single-entry buffer of the requester that issued it.
module log_req_arbiter
    import awgn_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DIN_W  = LOG_DIN_W,
    parameter int DOUT_W = LOG_DOUT_W,
    parameter int LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DIN_W-1:0]  req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [DIN_W-1:0]       log_in,
    input  logic [DOUT_W-1:0]      log_out,
    output logic [NREQ-1:0]        res_valid,
    output logic [NREQ*DOUT_W-1:0] res_data,
    input  logic [NREQ-1:0]        res_ready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   r_credit;
    logic [NREQ-1:0]   r_res_valid;
    logic [IW-1:0]     r_ptr;
    logic [DIN_W-1:0]  r_log_in;
    logic [DOUT_W-1:0] r_res_data [NREQ];
    tag_t              r_tag [LAT+1];

    logic [NREQ-1:0]   w_elig;
    logic [NREQ-1:0]   w_grant;
    logic [IW-1:0]     w_idx;
    logic              w_accept;
    logic [NREQ-1:0]   w_hs;

    assign w_elig   = req_valid & r_credit;
    assign w_accept = |w_elig;
    assign w_hs     = r_res_valid & res_ready;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .i_ptr   (r_ptr),
        .i_req   (w_elig),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit    <= '1;
            r_res_valid <= '0;
            r_ptr       <= '0;
            r_log_in    <= '0;
            for (int s = 0; s <= LAT; s++) r_tag[s] <= '0;
            for (int k = 0; k < NREQ; k++) r_res_data[k] <= '0;
        end else begin
            if (w_accept) begin
                r_log_in <= req_data[w_idx*DIN_W +: DIN_W];
                r_ptr    <= IW'(wrap_inc(int'(w_idx), NREQ));
            end
            // Stage 0 lines up with log_in, stage LAT with log_out.
            r_tag[0] <= tag_t'{v: w_accept, id: TAG_ID_W'(w_idx)};
            for (int s = 1; s <= LAT; s++) r_tag[s] <= r_tag[s-1];
            // A buffer can only fill while its credit is 0, so fill and drain never collide.
            for (int k = 0; k < NREQ; k++) begin
                if (w_grant[k]) r_credit[k] <= 1'b0;
                else if (w_hs[k]) r_credit[k] <= 1'b1;
                if (r_tag[LAT].v && (r_tag[LAT].id == TAG_ID_W'(k))) begin
                    r_res_valid[k] <= 1'b1;
                    r_res_data[k]  <= log_out;
                end else if (w_hs[k]) begin
                    r_res_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign req_ready = w_grant;
    assign log_in    = r_log_in;
    assign res_valid = r_res_valid;

    for (genvar k = 0; k < NREQ; k++) begin : g_res
        assign res_data[k*DOUT_W +: DOUT_W] = r_res_data[k];
    end

endmodule
